// File: rtl/cmp_run_monitor.sv
// Run-completion monitor: watches each node's fetched instruction for END_INST, times the run,
// holds a flush window, then reports done or timeout. All outputs are registered.
module cmp_run_monitor #(
  parameter int              NUM_NODES    = 4,
  parameter int              INST_W       = 32,
  parameter int              CNT_W        = 32,
  parameter logic [INST_W-1:0] END_INST   = '0,
  parameter int              FLUSH_CYCLES = 5,
  parameter longint unsigned TIMEOUT      = 500,
  parameter bit              STICKY       = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_NODES*INST_W-1:0]  node_inst,
  output logic [NUM_NODES-1:0]         node_done,
  output logic [NUM_NODES*CNT_W-1:0]   node_end_cycle,
  output logic [CNT_W-1:0]             cycle_count,
  output logic [CNT_W-1:0]             run_cycles,
  output logic                         flush_active,
  output logic                         run_done,
  output logic                         timeout,
  output logic [1:0]                   state
);

  typedef enum logic [1:0] {
    S_RUN     = 2'b00,
    S_FLUSH   = 2'b01,
    S_DONE    = 2'b10,
    S_TIMEOUT = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam int               FL_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FL_W-1:0]  FL_LOAD = FL_W'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

  state_t                 state_q;
  state_t                 state_d;
  logic [FL_W-1:0]        flush_cnt;
  logic [NUM_NODES-1:0]   hit;
  logic                   all_end;
  logic                   counting;
  logic                   flush_d;
  logic                   done_d;
  logic                   timeout_d;

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_NODES; i++) begin
      hit[i] = (node_inst[i*INST_W +: INST_W] == END_INST);
    end
  end

  // Sticky mode counts an earlier latched end; otherwise every node must be at END_INST together.
  assign all_end  = STICKY ? &(node_done | hit) : &hit;
  assign counting = (state_q == S_RUN) || (state_q == S_FLUSH);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_RUN;
      flush_active <= 1'b0;
      run_done     <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_active <= flush_d;
      run_done     <= done_d;
      timeout      <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (all_end) begin
          state_d = (FLUSH_CYCLES == 0) ? S_DONE : S_FLUSH;
        end else if (cycle_count == TO_LAST) begin
          state_d = S_TIMEOUT;
        end
      end
      S_FLUSH: begin
        if (flush_cnt == '0) begin
          state_d = S_DONE;
        end
      end
      default: state_d = state_q;
    endcase
  end

  // Flags are decoded from the next state so they register alongside it.
  always_comb begin
    flush_d   = (state_d == S_FLUSH);
    done_d    = (state_d == S_DONE);
    timeout_d = (state_d == S_TIMEOUT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_count    <= '0;
      run_cycles     <= '0;
      node_done      <= '0;
      node_end_cycle <= '0;
      flush_cnt      <= '0;
    end else if (counting) begin
      if (!(&cycle_count)) begin
        cycle_count <= cycle_count + CNT_W'(1);
      end
      for (int i = 0; i < NUM_NODES; i++) begin
        if (hit[i] && !node_done[i]) begin
          node_done[i]                      <= 1'b1;
          node_end_cycle[i*CNT_W +: CNT_W]  <= cycle_count;
        end
      end
      if (state_q == S_RUN) begin
        if (all_end) begin
          run_cycles <= cycle_count;
          flush_cnt  <= FL_LOAD;
        end
      end else if (flush_cnt != '0) begin
        flush_cnt <= flush_cnt - FL_W'(1);
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_cmp_run_monitor.sv
// Bench for cmp_run_monitor: four configurations driven together, checked every cycle
// against a behavioural model, plus hand-computed checkpoints for the directed runs.
module tb_cmp_run_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic [127:0]   inst4;
  logic [255:0]   inst8;
  logic           armed = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  logic [3:0]   a_done, b_done, c_done;
  logic [7:0]   d_done;
  logic [127:0] a_endc, b_endc, c_endc;
  logic [31:0]  d_endc;
  logic [31:0]  a_cnt, b_cnt, c_cnt, a_runc, b_runc, c_runc;
  logic [3:0]   d_cnt, d_runc;
  logic         a_fa, a_rd, a_to, b_fa, b_rd, b_to, c_fa, c_rd, c_to, d_fa, d_rd, d_to;
  logic [1:0]   a_st, b_st, c_st, d_st;

  cmp_run_monitor #(.NUM_NODES(4), .INST_W(32), .CNT_W(32), .END_INST(32'd0),
                    .FLUSH_CYCLES(5), .TIMEOUT(500), .STICKY(1'b1)) dut_a (
    .clk(clk), .reset(reset), .node_inst(inst4), .node_done(a_done), .node_end_cycle(a_endc),
    .cycle_count(a_cnt), .run_cycles(a_runc), .flush_active(a_fa), .run_done(a_rd),
    .timeout(a_to), .state(a_st));

  cmp_run_monitor #(.NUM_NODES(4), .INST_W(32), .CNT_W(32), .END_INST(32'd0),
                    .FLUSH_CYCLES(5), .TIMEOUT(500), .STICKY(1'b0)) dut_b (
    .clk(clk), .reset(reset), .node_inst(inst4), .node_done(b_done), .node_end_cycle(b_endc),
    .cycle_count(b_cnt), .run_cycles(b_runc), .flush_active(b_fa), .run_done(b_rd),
    .timeout(b_to), .state(b_st));

  cmp_run_monitor #(.NUM_NODES(4), .INST_W(32), .CNT_W(32), .END_INST(32'd0),
                    .FLUSH_CYCLES(0), .TIMEOUT(500), .STICKY(1'b1)) dut_c (
    .clk(clk), .reset(reset), .node_inst(inst4), .node_done(c_done), .node_end_cycle(c_endc),
    .cycle_count(c_cnt), .run_cycles(c_runc), .flush_active(c_fa), .run_done(c_rd),
    .timeout(c_to), .state(c_st));

  cmp_run_monitor #(.NUM_NODES(8), .INST_W(32), .CNT_W(4), .END_INST(32'd0),
                    .FLUSH_CYCLES(5), .TIMEOUT(15), .STICKY(1'b1)) dut_d (
    .clk(clk), .reset(reset), .node_inst(inst8), .node_done(d_done), .node_end_cycle(d_endc),
    .cycle_count(d_cnt), .run_cycles(d_runc), .flush_active(d_fa), .run_done(d_rd),
    .timeout(d_to), .state(d_st));

  // Per-instance configuration and model state; phase 0 run, 1 flush, 2 done, 3 timeout.
  int     cfg_n[4]      = '{4, 4, 4, 8};
  int     cfg_sticky[4] = '{1, 0, 1, 1};
  int     cfg_fl[4]     = '{5, 5, 0, 5};
  longint cfg_to[4]     = '{500, 500, 500, 15};
  int     cfg_w[4]      = '{32, 32, 32, 4};

  int         m_ph[4];
  longint     m_cnt[4];
  logic [7:0] m_done[4];
  longint     m_endc[4][8];
  longint     m_runc[4];
  int         m_fl[4];

  function automatic logic [7:0] hits_of(input int k);
    logic [7:0] h = '0;
    if (k == 3) begin
      for (int i = 0; i < 8; i++) h[i] = (inst8[i*32 +: 32] == 32'd0);
    end else begin
      for (int i = 0; i < 4; i++) h[i] = (inst4[i*32 +: 32] == 32'd0);
    end
    return h;
  endfunction

  task automatic model_reset(input int k);
    m_ph[k] = 0; m_cnt[k] = 0; m_done[k] = '0; m_runc[k] = 0; m_fl[k] = 0;
    for (int i = 0; i < 8; i++) m_endc[k][i] = 0;
  endtask

  task automatic model_step(input int k, input logic rst_n);
    logic [7:0] h;
    logic       all_end;
    longint     old, mx;
    h  = hits_of(k);
    mx = (longint'(1) << cfg_w[k]) - 1;
    if (!rst_n) begin
      model_reset(k);
    end else if (m_ph[k] <= 1) begin
      old     = m_cnt[k];
      all_end = 1'b1;
      for (int i = 0; i < cfg_n[k]; i++) begin
        if (cfg_sticky[k] != 0) all_end &= (m_done[k][i] | h[i]);
        else                    all_end &= h[i];
      end
      for (int i = 0; i < cfg_n[k]; i++) begin
        if (h[i] && !m_done[k][i]) begin
          m_done[k][i] = 1'b1;
          m_endc[k][i] = old;
        end
      end
      m_cnt[k] = (old < mx) ? old + 1 : old;
      if (m_ph[k] == 0) begin
        if (all_end) begin
          m_runc[k] = old;
          if (cfg_fl[k] == 0) m_ph[k] = 2;
          else begin m_ph[k] = 1; m_fl[k] = 0; end
        end else if (old == cfg_to[k] - 1) begin
          m_ph[k] = 3;
        end
      end else begin
        m_fl[k]++;
        if (m_fl[k] == cfg_fl[k]) m_ph[k] = 2;
      end
    end
  endtask

  task automatic chk(input int k, input logic [1:0] st, input logic [63:0] cnt,
                     input logic [63:0] runc, input logic [7:0] nd, input logic [255:0] ef,
                     input logic fa, input logic rd, input logic to);
    logic [63:0] mx, got;
    logic [2:0]  fl_got, fl_exp;
    bit          endc_ok = 1'b1;
    mx = (64'd1 << cfg_w[k]) - 64'd1;
    for (int i = 0; i < cfg_n[k]; i++) begin
      got = 64'(ef >> (i * cfg_w[k])) & mx;
      if (got !== 64'(m_endc[k][i])) endc_ok = 1'b0;
    end
    fl_got = {fa, rd, to};
    fl_exp = {m_ph[k] == 1, m_ph[k] == 2, m_ph[k] == 3};
    n_chk++;
    if (st !== 2'(m_ph[k]) || cnt !== 64'(m_cnt[k]) || runc !== 64'(m_runc[k]) ||
        nd !== m_done[k] || fl_got !== fl_exp || !endc_ok) begin
      n_fail++;
      $display("FAIL dut%0d model @%0t: state %0d exp %0d, count %0d exp %0d, run_cycles %0d exp %0d, done %h exp %h, flags %b exp %b, end_cycles_ok %0d",
               k, $time, st, m_ph[k], cnt, m_cnt[k], runc, m_runc[k], nd, m_done[k],
               fl_got, fl_exp, endc_ok);
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) model_reset(k);
    forever begin
      @(negedge clk);
      if (armed) begin
        chk(0, a_st, 64'(a_cnt), 64'(a_runc), 8'(a_done), 256'(a_endc), a_fa, a_rd, a_to);
        chk(1, b_st, 64'(b_cnt), 64'(b_runc), 8'(b_done), 256'(b_endc), b_fa, b_rd, b_to);
        chk(2, c_st, 64'(c_cnt), 64'(c_runc), 8'(c_done), 256'(c_endc), c_fa, c_rd, c_to);
        chk(3, d_st, 64'(d_cnt), 64'(d_runc), d_done, 256'(d_endc), d_fa, d_rd, d_to);
      end
      for (int k = 0; k < 4; k++) model_step(k, reset);
    end
  end

  task automatic lit(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [31:0] rnz();
    logic [31:0] v = $urandom;
    if (v == 32'd0) v = 32'd1;
    return v;
  endfunction

  task automatic drive(input logic [3:0] e4, input logic [7:0] e8);
    for (int i = 0; i < 4; i++) inst4[i*32 +: 32] = e4[i] ? 32'd0 : rnz();
    for (int i = 0; i < 8; i++) inst8[i*32 +: 32] = e8[i] ? 32'd0 : rnz();
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(4'h0, 8'h00);
    cyc();
    armed = 1'b1;
    cyc();
    reset = 1'b1;
  endtask

  function automatic logic [3:0] s1_ends(input int k);
    int e[4] = '{10, 12, 15, 20};
    logic [3:0] m = '0;
    for (int i = 0; i < 4; i++) m[i] = (k == e[i]);
    return m;
  endfunction

  initial begin
    int thr_tab[4] = '{0, 10, 125, 500};
    int thr4, thr8;
    logic [3:0] e4;
    logic [7:0] e8;

    do_reset();
    lit("reset state", 64'(a_st), 0);
    lit("reset count", 64'(a_cnt), 0);
    lit("reset done", 64'(a_done), 0);
    lit("reset count 4b", 64'(d_cnt), 0);

    // Staggered single-cycle end pulses: sticky completes, same-cycle mode times out.
    for (int k = 0; k <= 510; k++) begin
      drive(s1_ends(k), 8'h00);
      cyc();
      if (k == 14) begin
        lit("small timeout state", 64'(d_st), 3);
        lit("small timeout count", 64'(d_cnt), 15);
      end
      if (k == 20) begin
        lit("noflush state", 64'(c_st), 2);
        lit("noflush count", 64'(c_cnt), 21);
      end
      if (k == 24) begin
        lit("flush state", 64'(a_st), 1);
        lit("flush flag", 64'(a_fa), 1);
      end
      if (k == 25) begin
        lit("done state", 64'(a_st), 2);
        lit("done flag", 64'(a_rd), 1);
        lit("done count", 64'(a_cnt), 26);
        lit("run cycles", 64'(a_runc), 20);
        lit("end cycle 0", 64'(a_endc[31:0]), 10);
        lit("end cycle 1", 64'(a_endc[63:32]), 12);
        lit("end cycle 2", 64'(a_endc[95:64]), 15);
        lit("end cycle 3", 64'(a_endc[127:96]), 20);
      end
      if (k == 498) lit("pre-timeout state", 64'(b_st), 0);
      if (k == 499) begin
        lit("timeout state", 64'(b_st), 3);
        lit("timeout flag", 64'(b_to), 1);
        lit("timeout count", 64'(b_cnt), 500);
        lit("timeout node_done", 64'(b_done), 15);
      end
    end
    lit("frozen done count", 64'(a_cnt), 26);
    lit("frozen small count", 64'(d_cnt), 15);

    // All nodes end on the last RUN cycle before timeout.
    do_reset();
    for (int k = 0; k <= 505; k++) begin
      drive((k == 499) ? 4'hf : 4'h0, 8'h00);
      cyc();
      if (k == 499) begin
        lit("race state", 64'(b_st), 1);
        lit("race timeout", 64'(b_to), 0);
        lit("race run cycles", 64'(b_runc), 499);
      end
    end

    // Reset arriving on the second flush cycle.
    do_reset();
    for (int k = 0; k <= 22; k++) begin
      drive(s1_ends(k), 8'h00);
      if (k == 22) reset = 1'b0;
      cyc();
      if (k == 21) lit("pre-reset flush", 64'(a_st), 1);
    end
    lit("flush reset state", 64'(a_st), 0);
    lit("flush reset count", 64'(a_cnt), 0);
    lit("flush reset done", 64'(a_done), 0);
    lit("flush reset flag", 64'(a_fa), 0);
    lit("flush reset endc", 64'(|a_endc), 0);
    reset = 1'b1;

    // Zero-length flush.
    do_reset();
    for (int k = 0; k <= 12; k++) begin
      drive((k == 7) ? 4'hf : 4'h0, 8'h00);
      cyc();
      if (k == 6) lit("noflush pre state", 64'(c_st), 0);
      if (k == 7) begin
        lit("noflush done state", 64'(c_st), 2);
        lit("noflush done flag", 64'(c_rd), 1);
        lit("noflush flush flag", 64'(c_fa), 0);
        lit("noflush done count", 64'(c_cnt), 8);
      end
    end

    // Random runs with varying end density and occasional resets.
    for (int r = 0; r < 8; r++) begin
      do_reset();
      thr4 = thr_tab[$urandom_range(0, 3)];
      thr8 = thr_tab[$urandom_range(0, 3)];
      for (int k = $urandom_range(40, 560); k > 0; k--) begin
        for (int i = 0; i < 4; i++) e4[i] = ($urandom_range(0, 999) < thr4);
        for (int i = 0; i < 8; i++) e8[i] = ($urandom_range(0, 999) < thr8);
        drive(e4, e8);
        reset = ($urandom_range(0, 299) != 0);
        cyc();
      end
      reset = 1'b1;
    end

    cyc();
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
